// File: rtl/ul_sim_session_ctrl_pkg.sv
// Shared types for the SIM session sequencer: state/command codes, status bit
// offsets and the pin pattern driven in each state.
package ul_sim_session_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_OFF       = 4'd0,
      ST_VCC_UP    = 4'd1,
      ST_RST_LOW   = 4'd2,
      ST_ATR_WAIT  = 4'd3,
      ST_ACTIVE    = 4'd4,
      ST_DEACT_RST = 4'd5,
      ST_DEACT_CLK = 4'd6,
      ST_DEACT_VCC = 4'd7
   } sim_state_e;

   typedef enum logic [1:0] {
      CMD_NOP        = 2'd0,
      CMD_ACTIVATE   = 2'd1,
      CMD_WARM_RESET = 2'd2,
      CMD_DEACTIVATE = 2'd3
   } sim_cmd_e;

   localparam int STAT_ATR_TO   = 4;
   localparam int STAT_WWT_TO   = 5;
   localparam int STAT_CMD_ERR  = 6;
   localparam int STAT_ATR_SEEN = 7;

   typedef struct packed {
      logic vcc_en;
      logic stopn;
      logic reset;
      logic uart_resetn;
   } sim_pins_t;

   function automatic sim_pins_t pins_for(input sim_state_e st);
      sim_pins_t p;
      p = '0;
      case (st)
         ST_VCC_UP:                p = '{vcc_en: 1'b1, stopn: 1'b0, reset: 1'b0, uart_resetn: 1'b0};
         ST_RST_LOW, ST_DEACT_RST: p = '{vcc_en: 1'b1, stopn: 1'b1, reset: 1'b0, uart_resetn: 1'b1};
         ST_ATR_WAIT, ST_ACTIVE:   p = '{vcc_en: 1'b1, stopn: 1'b1, reset: 1'b1, uart_resetn: 1'b1};
         ST_DEACT_CLK:             p = '{vcc_en: 1'b1, stopn: 1'b0, reset: 1'b0, uart_resetn: 1'b0};
         default:                  p = '0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/ul_sim_session_ctrl_tick.sv
// ul_sim_tick_timer: counts sim ticks from a clear; done flags the tick on
// which the count reaches limit-1, so a phase lasts exactly limit ticks.
module ul_sim_tick_timer #(
   parameter int CNT_BITS = 22
) (
   input  logic                axis_clk,
   input  logic                resetn,
   input  logic                clr,
   input  logic                tick,
   input  logic [CNT_BITS-1:0] limit,
   output logic                done
);

   logic [CNT_BITS-1:0] count;

   always_ff @(posedge axis_clk or negedge resetn) begin
      if (!resetn)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (tick)
         count <= count + CNT_BITS'(1);
   end

   assign done = tick && (count == (limit - CNT_BITS'(1)));

endmodule

// File: rtl/ul_sim_session_ctrl.sv
// SIM session sequencer: ISO 7816-3 activation / warm reset / deactivation,
// ATR timeout and work-waiting-time supervision.
//
// state        | meaning
// OFF          | card unpowered, UART held in reset
// VCC_UP       | VCC on, waiting for supply to settle
// RST_LOW      | clock running, RST held low
// ATR_WAIT     | RST released, waiting for first ATR character
// ACTIVE       | session up, WWT supervised once armed by a transmit
// DEACT_RST    | RST dropped
// DEACT_CLK    | clock stopped, UART held in reset
// DEACT_VCC    | VCC dropped, returns to OFF
module ul_sim_session_ctrl
   import ul_sim_session_ctrl_pkg::*;
#(
   parameter int unsigned VCC_SETTLE_TICKS  = 200,
   parameter int unsigned RST_LOW_TICKS     = 400,
   parameter int unsigned ATR_TIMEOUT_TICKS = 40000,
   parameter int unsigned WWT_TICKS         = 3571200,
   parameter int unsigned DEACT_STEP_TICKS  = 8,
   parameter int          CNT_BITS          = 22
) (
   input  logic        axis_clk,
   input  logic        resetn,
   input  logic        sim_tick,
   input  logic        rx_strobe,
   input  logic        tx_strobe,
   input  logic [1:0]  axis_cmd_data,
   input  logic        axis_cmd_valid,
   output logic        axis_cmd_ready,
   output logic [31:0] axis_stat_data,
   output logic        axis_stat_valid,
   input  logic        axis_stat_ready,
   output logic        sim_vcc_en,
   output logic        sim_stopn,
   output logic        sim_reset,
   output logic        uart_resetn,
   output logic        int_evt_valid,
   input  logic        int_evt_ready
);

   sim_state_e          state, state_nxt;
   sim_cmd_e            cmd;
   sim_pins_t           pins_q;
   logic                cmd_taken;
   logic                phase_clr, phase_done, wwt_clr, wwt_done;
   logic [CNT_BITS-1:0] phase_limit;
   logic                wwt_armed, wwt_armed_nxt;
   logic                atr_seen, atr_seen_nxt;
   logic                set_atr_to, set_wwt_to, set_cmd_err;
   logic                flag_atr_to, flag_wwt_to, flag_cmd_err;
   logic                evt_pend, evt_q;

   always_comb begin
      phase_limit = '1;
      case (state)
         ST_VCC_UP:   phase_limit = CNT_BITS'(VCC_SETTLE_TICKS);
         ST_RST_LOW:  phase_limit = CNT_BITS'(RST_LOW_TICKS);
         ST_ATR_WAIT: phase_limit = CNT_BITS'(ATR_TIMEOUT_TICKS);
         ST_DEACT_RST, ST_DEACT_CLK, ST_DEACT_VCC:
                      phase_limit = CNT_BITS'(DEACT_STEP_TICKS);
         default:     phase_limit = '1;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      cmd_taken     = 1'b0;
      atr_seen_nxt  = atr_seen;
      wwt_armed_nxt = wwt_armed;
      set_atr_to    = 1'b0;
      set_wwt_to    = 1'b0;
      set_cmd_err   = 1'b0;
      cmd           = axis_cmd_valid ? sim_cmd_e'(axis_cmd_data) : CMD_NOP;

      // An accepted command pre-empts any timer expiry in the same cycle.
      case (cmd)
         CMD_ACTIVATE: begin
            if (state == ST_OFF) begin
               state_nxt    = ST_VCC_UP;
               atr_seen_nxt = 1'b0;
               cmd_taken    = 1'b1;
            end else
               set_cmd_err = 1'b1;
         end
         CMD_WARM_RESET: begin
            if (state inside {ST_ATR_WAIT, ST_ACTIVE}) begin
               state_nxt    = ST_RST_LOW;
               atr_seen_nxt = 1'b0;
               cmd_taken    = 1'b1;
            end else
               set_cmd_err = 1'b1;
         end
         CMD_DEACTIVATE: begin
            if (state inside {ST_VCC_UP, ST_RST_LOW, ST_ATR_WAIT, ST_ACTIVE}) begin
               state_nxt = ST_DEACT_RST;
               cmd_taken = 1'b1;
            end else if (state == ST_OFF)
               set_cmd_err = 1'b1;
         end
         default: ;
      endcase

      if (!cmd_taken) begin
         case (state)
            ST_VCC_UP:    if (phase_done) state_nxt = ST_RST_LOW;
            ST_RST_LOW:   if (phase_done) state_nxt = ST_ATR_WAIT;
            ST_ATR_WAIT: begin
               if (rx_strobe) begin
                  state_nxt    = ST_ACTIVE;
                  atr_seen_nxt = 1'b1;
               end else if (phase_done) begin
                  state_nxt  = ST_DEACT_RST;
                  set_atr_to = 1'b1;
               end
            end
            ST_ACTIVE:    if (wwt_armed && wwt_done && !rx_strobe && !tx_strobe) set_wwt_to = 1'b1;
            ST_DEACT_RST: if (phase_done) state_nxt = ST_DEACT_CLK;
            ST_DEACT_CLK: if (phase_done) state_nxt = ST_DEACT_VCC;
            ST_DEACT_VCC: if (phase_done) state_nxt = ST_OFF;
            default: ;
         endcase
      end

      if (state == ST_ACTIVE && state_nxt == ST_ACTIVE) begin
         if (set_wwt_to)
            wwt_armed_nxt = 1'b0;
         else if (tx_strobe)
            wwt_armed_nxt = 1'b1;
      end else
         wwt_armed_nxt = 1'b0;
   end

   assign phase_clr = (state_nxt != state);
   // Restart on any strobe; held at zero whenever not armed.
   assign wwt_clr   = !(wwt_armed && wwt_armed_nxt) || rx_strobe || tx_strobe;

   ul_sim_tick_timer #(.CNT_BITS(CNT_BITS)) u_phase_timer (
      .axis_clk (axis_clk),
      .resetn   (resetn),
      .clr      (phase_clr),
      .tick     (sim_tick),
      .limit    (phase_limit),
      .done     (phase_done)
   );

   ul_sim_tick_timer #(.CNT_BITS(CNT_BITS)) u_wwt_timer (
      .axis_clk (axis_clk),
      .resetn   (resetn),
      .clr      (wwt_clr),
      .tick     (sim_tick),
      .limit    (CNT_BITS'(WWT_TICKS)),
      .done     (wwt_done)
   );

   always_ff @(posedge axis_clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_OFF;
         pins_q       <= '0;
         atr_seen     <= 1'b0;
         wwt_armed    <= 1'b0;
         flag_atr_to  <= 1'b0;
         flag_wwt_to  <= 1'b0;
         flag_cmd_err <= 1'b0;
         evt_pend     <= 1'b0;
         evt_q        <= 1'b0;
      end else begin
         state        <= state_nxt;
         pins_q       <= pins_for(state_nxt);
         atr_seen     <= atr_seen_nxt;
         wwt_armed    <= wwt_armed_nxt;
         flag_atr_to  <= set_atr_to  | (flag_atr_to  & ~axis_stat_ready);
         flag_wwt_to  <= set_wwt_to  | (flag_wwt_to  & ~axis_stat_ready);
         flag_cmd_err <= set_cmd_err | (flag_cmd_err & ~axis_stat_ready);
         evt_pend     <= set_atr_to | set_wwt_to;
         evt_q        <= evt_pend | (evt_q & ~int_evt_ready);
      end
   end

   assign axis_cmd_ready  = 1'b1;
   assign axis_stat_valid = 1'b1;
   assign axis_stat_data  = {24'h0, atr_seen, flag_cmd_err, flag_wwt_to, flag_atr_to, state};
   assign sim_vcc_en      = pins_q.vcc_en;
   assign sim_stopn       = pins_q.stopn;
   assign sim_reset       = pins_q.reset;
   assign uart_resetn     = pins_q.uart_resetn;
   assign int_evt_valid   = evt_q;

endmodule
